// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate-generation stage: extop encoding and
// the entry layout carried through the stage.
package imm_gen_pkg;

    localparam int EXTOP_W = 3;

    localparam logic [EXTOP_W-1:0] EXT_NONE = 3'd0;
    localparam logic [EXTOP_W-1:0] EXT_R    = 3'd1;
    localparam logic [EXTOP_W-1:0] EXT_I    = 3'd2;
    localparam logic [EXTOP_W-1:0] EXT_S    = 3'd3;
    localparam logic [EXTOP_W-1:0] EXT_B    = 3'd4;
    localparam logic [EXTOP_W-1:0] EXT_U    = 3'd5;
    localparam logic [EXTOP_W-1:0] EXT_J    = 3'd6;
    localparam logic [EXTOP_W-1:0] EXT_Z    = 3'd7;

    localparam int XLEN_MAX  = 64;
    localparam int TAG_W_MAX = 64;

    // Entry layout at the widest configuration; consumers that work at the
    // default XLEN/TAG_W exchange entries in this form.
    typedef struct packed {
        logic [XLEN_MAX-1:0]  imm;
        logic [EXTOP_W-1:0]   extop;
        logic [TAG_W_MAX-1:0] tag;
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate extractor: instruction bits [31:7] plus a format
// select produce an XLEN-wide immediate. Also used by the branch predictor.
module imm_gen_core
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [24:0]        inst,
    input  logic [EXTOP_W-1:0] extop,
    output logic [XLEN-1:0]    imm
);

    // inst[k] of the full instruction lives at inst[k-7] here; inst[24] is the sign bit.
    logic sgn;
    assign sgn = inst[24];

    // Widen a 32-bit signed immediate to XLEN by sign extension.
    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // Format decode: each case assembles the 32-bit form, then widens it.
    always_comb begin
        imm = '0;
        case (extop)
            EXT_I:   imm = sext32({{20{sgn}}, inst[24:13]});
            EXT_S:   imm = sext32({{20{sgn}}, inst[24:18], inst[4:0]});
            EXT_B:   imm = sext32({{19{sgn}}, inst[24], inst[0], inst[23:18], inst[4:1], 1'b0});
            EXT_U:   imm = sext32({inst[24:5], 12'b0});
            EXT_J:   imm = sext32({{11{sgn}}, inst[24], inst[12:5], inst[13], inst[23:14], 1'b0});
            EXT_Z:   imm = XLEN'(inst[12:8]);
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered, handshaked immediate-generation stage with a 2-entry skid
// buffer (main entry drives the outputs, skid entry absorbs one beat of
// back-pressure). in_ready depends only on registered state.
// Optional: define IMM_GEN_STAGE_ILLEGAL_CHK_EN to add the out_illegal flag.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [24:0]        in_inst,
    input  logic [EXTOP_W-1:0] in_extop,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_imm,
    output logic [EXTOP_W-1:0] out_extop,
    output logic [TAG_W-1:0]   out_tag
`ifdef IMM_GEN_STAGE_ILLEGAL_CHK_EN
    ,
    output logic               out_illegal
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    // Same field layout as imm_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0]    imm;
        logic [EXTOP_W-1:0] extop;
        logic [TAG_W-1:0]   tag;
    } entry_t;

    // ---- p0: input side, combinational immediate ----
    logic [XLEN-1:0] imm_p0;
    entry_t          new_p0;

    imm_gen_core #(.XLEN(XLEN)) u_core (
        .inst  (in_inst),
        .extop (in_extop),
        .imm   (imm_p0)
    );

    assign new_p0 = '{imm: imm_p0, extop: in_extop, tag: in_tag};

    // ---- p1: registered main and skid entries ----
    entry_t main_p1;
    entry_t skid_p1;
    logic   main_valid_p1;
    logic   skid_valid_p1;

    logic in_fire;
    logic out_fire;
    logic take;
    logic main_from_in;
    logic main_from_skid;
    logic skid_from_in;

    assign in_ready = !skid_valid_p1;

    // Load steering: a flushed input is never taken; the skid refills main first.
    always_comb begin
        in_fire        = in_valid & !skid_valid_p1;
        out_fire       = main_valid_p1 & out_ready;
        take           = in_fire & !flush;
        main_from_skid = out_fire & skid_valid_p1;
        main_from_in   = take & (!main_valid_p1 | (out_fire & !skid_valid_p1));
        skid_from_in   = take & main_valid_p1 & !out_fire;
    end

    // Occupancy flags: flush empties both entries on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_p1 <= 1'b0;
            skid_valid_p1 <= 1'b0;
        end else if (flush) begin
            main_valid_p1 <= 1'b0;
            skid_valid_p1 <= 1'b0;
        end else begin
            main_valid_p1 <= main_from_in | main_from_skid | (main_valid_p1 & !out_fire);
            skid_valid_p1 <= skid_from_in | (skid_valid_p1 & !out_fire);
        end
    end

    // Entry payloads: main changes only when empty or consumed, so outputs hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            if (main_from_skid) begin
                main_p1 <= skid_p1;
            end else if (main_from_in) begin
                main_p1 <= new_p0;
            end
            if (skid_from_in) begin
                skid_p1 <= new_p0;
            end
        end
    end

    assign out_valid = main_valid_p1;
    assign out_imm   = main_p1.imm;
    assign out_extop = main_p1.extop;
    assign out_tag   = main_p1.tag;

`ifdef IMM_GEN_STAGE_ILLEGAL_CHK_EN
    logic ill_p0;
    logic main_ill_p1;
    logic skid_ill_p1;

    assign ill_p0 = in_valid & (in_extop == EXT_NONE);

    // Illegal flag follows its entry through main/skid and dies with it on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ill_p1 <= 1'b0;
            skid_ill_p1 <= 1'b0;
        end else if (flush) begin
            main_ill_p1 <= 1'b0;
            skid_ill_p1 <= 1'b0;
        end else begin
            if (main_from_skid) begin
                main_ill_p1 <= skid_ill_p1;
            end else if (main_from_in) begin
                main_ill_p1 <= ill_p0;
            end
            if (skid_from_in) begin
                skid_ill_p1 <= ill_p0;
            end
        end
    end

    assign out_illegal = main_ill_p1;
`endif

endmodule
